// File: rtl/uart_frame_pkg.sv
// Shared FSM state type and elaboration-time sizing helpers for the UART frame bridge.
package uart_frame_pkg;

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, SEND} state_e;

  // Bits needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

  function automatic int gap_clks(input int gap_bits, input int clk_hz, input int baud);
    return gap_bits * (clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_frame_bridge_if.sv
// Byte-side and vector-side handshake bundle of the frame bridge; master is the bridge.
interface uart_frame_bridge_if #(
  parameter int VEC_W = 1024
);
  logic [7:0]       rx_data_i;
  logic             rx_valid_i;
  logic [VEC_W-1:0] vec_o;
  logic             vec_valid_o;
  logic             vec_ready_i;
  logic [VEC_W-1:0] res_i;
  logic             res_valid_i;
  logic             res_ready_o;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic             busy_o;
  logic             frame_err_o;
  logic             overrun_o;

  modport master (
    input  rx_data_i, rx_valid_i, vec_ready_i, res_i, res_valid_i, tx_ready_i,
    output vec_o, vec_valid_o, res_ready_o, tx_data_o, tx_valid_o, busy_o, frame_err_o, overrun_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, vec_ready_i, res_i, res_valid_i, tx_ready_i,
    input  vec_o, vec_valid_o, res_ready_o, tx_data_o, tx_valid_o, busy_o, frame_err_o, overrun_o
  );
endinterface

// File: rtl/uart_frame_bridge_serializer.sv
// Parallel-load shift buffer emitting a frame byte 0 first; tx_valid follows load by one cycle.
// Each byte is held until tx_ready; done pulses combinationally on the last handshake.
module frame_byte_serializer
  import uart_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [8*FRAME_BYTES-1:0] data_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic                     done_o
);
  localparam int VEC_W = 8 * FRAME_BYTES;
  localparam int IDX_W = clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic [VEC_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             active_q, active_d;

  always_comb begin
    shift_d  = shift_q;
    idx_d    = idx_q;
    active_d = active_q;
    done_o   = 1'b0;
    if (load_i && !active_q) begin
      shift_d  = data_i;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (active_q && tx_ready_i) begin
      shift_d = shift_q >> 8;
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        active_d = 1'b0;
        done_o   = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign tx_valid_o = active_q;
  assign tx_data_o  = shift_q[7:0];
endmodule

// File: rtl/uart_frame_bridge.sv
// Assembles UART bytes into a vector frame, hands it to the core, streams the result back out.
// vec_valid one cycle after the last byte; vec/res/tx all valid-ready; rx bytes outside COLLECT are dropped as overrun.
module uart_frame_bridge
  import uart_frame_pkg::*;
#(
  parameter int N_WORDS    = 64,
  parameter int WORD_BYTES = 2,
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 1000000,
  parameter int GAP_BITS   = 32
) (
  input logic                clk,
  input logic                rst_n,
  uart_frame_bridge_if.master bus
);
  localparam int FRAME_BYTES = N_WORDS * WORD_BYTES;
  localparam int VEC_W       = 8 * FRAME_BYTES;
  localparam int GAP_CLKS    = gap_clks(GAP_BITS, CLK_HZ, BAUD);
  localparam int CNT_W       = clog2(FRAME_BYTES);
  localparam int GAP_W       = clog2(GAP_CLKS);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             ser_load;
  logic             ser_done;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    vec_d       = vec_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    ser_load    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.rx_valid_i) begin
          vec_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data_i;
          gap_cnt_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else if (GAP_CLKS != 0 && byte_cnt_q != '0) begin
          // Silence on the line mid-frame: drop the partial frame and resync on the next byte.
          if (gap_cnt_q == GAP_LAST) begin
            byte_cnt_d  = '0;
            gap_cnt_d   = '0;
            frame_err_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      ISSUE:   if (bus.vec_ready_i) state_d = WAIT;
      WAIT: begin
        if (bus.res_valid_i) begin
          ser_load = 1'b1;
          state_d  = SEND;
        end
      end
      SEND:    if (ser_done) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
    if (bus.rx_valid_i && state_q != COLLECT) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      vec_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      vec_q       <= vec_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  frame_byte_serializer #(.FRAME_BYTES(FRAME_BYTES)) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ser_load),
    .data_i     (bus.res_i),
    .tx_data_o  (bus.tx_data_o),
    .tx_valid_o (bus.tx_valid_o),
    .tx_ready_i (bus.tx_ready_i),
    .done_o     (ser_done)
  );

  assign bus.vec_o       = vec_q;
  assign bus.vec_valid_o = (state_q == ISSUE);
  assign bus.res_ready_o = (state_q == WAIT);
  assign bus.busy_o      = !((state_q == COLLECT) && (byte_cnt_q == '0));
  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_frame_bridge.sv
// Directed bench: default 128-byte bridge, a 4x3-byte bridge without timeout, and a single-byte bridge.
module tb_uart_frame_bridge;
  localparam int GAP = 3200;
  localparam int FB  = 128;
  localparam int VW  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] txq [0:FB-1];

  uart_frame_bridge_if #(.VEC_W(VW)) bi0 ();
  uart_frame_bridge_if #(.VEC_W(96)) bi1 ();
  uart_frame_bridge_if #(.VEC_W(8))  bi2 ();

  uart_frame_bridge dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0));
  uart_frame_bridge #(.N_WORDS(4), .WORD_BYTES(3), .GAP_BITS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1));
  uart_frame_bridge #(.N_WORDS(1), .WORD_BYTES(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bi2));

  function automatic logic [7:0] pat(input int sel, input int k);
    logic [7:0] a;
    case (k)
      0: a = 8'h01;
      1: a = 8'h3E;
      2: a = 8'h00;
      3: a = 8'hAD;
      4: a = 8'hF9;
      5: a = 8'h37;
      default: a = 8'(k * 13 + 5);
    endcase
    case (sel)
      0: return a;
      1: return 8'(k * 29 + 7);
      default: return ~a;
    endcase
  endfunction

  function automatic logic [VW-1:0] build_vec(input int sel);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < FB; k++) v[8*k +: 8] = pat(sel, k);
    return v;
  endfunction

  function automatic int first_diff(input logic [VW-1:0] a, input logic [VW-1:0] b);
    for (int k = 0; k < FB; k++) if (a[8*k +: 8] !== b[8*k +: 8]) return k;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bi0.rx_data_i  = b;
    bi0.rx_valid_i = 1'b1;
    @(negedge clk);
    bi0.rx_valid_i = 1'b0;
  endtask

  task automatic send_range(input int sel, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) send_byte(pat(sel, k));
  endtask

  task automatic handoff(input logic [VW-1:0] res);
    bi0.vec_ready_i = 1'b1;
    @(negedge clk);
    bi0.vec_ready_i = 1'b0;
    bi0.res_i       = res;
    bi0.res_valid_i = 1'b1;
    @(negedge clk);
    bi0.res_valid_i = 1'b0;
  endtask

  // Drives tx_ready at the given duty, records handshaken bytes and counts data/valid changes while stalled.
  task automatic run_tx(input int n, input int duty, output int got, output int unstable);
    logic [7:0] prev;
    bit stalled;
    stalled = 1'b0;
    prev = '0;
    got = 0;
    unstable = 0;
    for (int cyc = 0; cyc < 20000 && got < n; cyc++) begin
      if (stalled && (bi0.tx_valid_o !== 1'b1 || bi0.tx_data_o !== prev)) unstable++;
      bi0.tx_ready_i = ($urandom_range(99) < duty);
      stalled = bi0.tx_valid_o && !bi0.tx_ready_i;
      prev = bi0.tx_data_o;
      if (bi0.tx_valid_o && bi0.tx_ready_i) begin
        txq[got] = bi0.tx_data_o;
        got++;
      end
      @(negedge clk);
    end
    bi0.tx_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (bi0.vec_o !== '0) begin tests_failed++; $display("FAIL reset_vec_o: got %h want 0", bi0.vec_o); end
    tests_run++; if (bi0.vec_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_vec_valid: got %b want 0", bi0.vec_valid_o); end
    tests_run++; if (bi0.res_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_res_ready: got %b want 0", bi0.res_ready_o); end
    tests_run++; if (bi0.tx_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", bi0.tx_valid_o); end
    tests_run++; if (bi0.tx_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", bi0.tx_data_o); end
    tests_run++; if (bi0.busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bi0.busy_o); end
    tests_run++; if (bi0.frame_err_o !== 1'b0 || bi0.overrun_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got err=%b ovr=%b want 0 0", bi0.frame_err_o, bi0.overrun_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame_loopback;
    logic [VW-1:0] exp_v;
    int got, unst;
    exp_v = build_vec(0);
    send_byte(pat(0, 0));
    tests_run++; if (bi0.busy_o !== 1'b1) begin tests_failed++; $display("FAIL busy_first_byte: got %b want 1", bi0.busy_o); end
    send_range(0, 1, FB - 2);
    tests_run++; if (bi0.vec_valid_o !== 1'b0) begin tests_failed++; $display("FAIL vec_valid_early: got %b want 0", bi0.vec_valid_o); end
    send_byte(pat(0, FB - 1));
    tests_run++; if (bi0.vec_valid_o !== 1'b1) begin tests_failed++; $display("FAIL vec_valid_latency: got %b want 1", bi0.vec_valid_o); end
    tests_run++; if (bi0.vec_o[15:0] !== 16'h3E01) begin tests_failed++; $display("FAIL word0: got %h want 3e01", bi0.vec_o[15:0]); end
    tests_run++; if (bi0.vec_o[31:16] !== 16'hAD00) begin tests_failed++; $display("FAIL word1: got %h want ad00", bi0.vec_o[31:16]); end
    tests_run++; if (bi0.vec_o[47:32] !== 16'h37F9) begin tests_failed++; $display("FAIL word2: got %h want 37f9", bi0.vec_o[47:32]); end
    tests_run++; if (bi0.vec_o !== exp_v) begin
      tests_failed++; $display("FAIL frame_vec: first bad byte %0d got %h want %h", first_diff(bi0.vec_o, exp_v),
        bi0.vec_o[8*first_diff(bi0.vec_o, exp_v) +: 8], exp_v[8*first_diff(bi0.vec_o, exp_v) +: 8]);
    end
    handoff(exp_v);
    run_tx(FB, 100, got, unst);
    tests_run++; if (got !== FB) begin tests_failed++; $display("FAIL loop_count: got %0d want %0d", got, FB); end
    for (int k = 0; k < got; k++) begin
      tests_run++; if (txq[k] !== pat(0, k)) begin tests_failed++; $display("FAIL loop_byte%0d: got %h want %h", k, txq[k], pat(0, k)); end
    end
    tests_run++; if (bi0.busy_o !== 1'b0 || bi0.tx_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL loop_idle: got busy=%b tx_valid=%b want 0 0", bi0.busy_o, bi0.tx_valid_o);
    end
  endtask

  task automatic test_backpressure;
    logic [VW-1:0] exp_v;
    int got, unst, bad, extra;
    exp_v = build_vec(1);
    send_range(1, 0, FB - 1);
    bad = 0;
    repeat (7) begin
      if (bi0.vec_valid_o !== 1'b1 || bi0.vec_o !== exp_v) bad++;
      @(negedge clk);
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL vec_hold: got %0d unstable cycles want 0", bad); end
    bi0.vec_ready_i = 1'b1;
    @(negedge clk);
    bi0.vec_ready_i = 1'b0;
    tests_run++; if (bi0.vec_valid_o !== 1'b0) begin tests_failed++; $display("FAIL vec_drop: got %b want 0", bi0.vec_valid_o); end
    repeat (3) @(negedge clk);
    tests_run++; if (bi0.res_ready_o !== 1'b1) begin tests_failed++; $display("FAIL res_ready_wait: got %b want 1", bi0.res_ready_o); end
    bi0.res_i = build_vec(2);
    bi0.res_valid_i = 1'b1;
    @(negedge clk);
    bi0.res_valid_i = 1'b0;
    tests_run++; if (bi0.res_ready_o !== 1'b0) begin tests_failed++; $display("FAIL res_ready_drop: got %b want 0", bi0.res_ready_o); end
    run_tx(FB, 50, got, unst);
    tests_run++; if (got !== FB) begin tests_failed++; $display("FAIL bp_count: got %0d want %0d", got, FB); end
    tests_run++; if (unst !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d changes under stall want 0", unst); end
    for (int k = 0; k < got; k++) begin
      tests_run++; if (txq[k] !== pat(2, k)) begin tests_failed++; $display("FAIL bp_byte%0d: got %h want %h", k, txq[k], pat(2, k)); end
    end
    extra = 0;
    bi0.tx_ready_i = 1'b1;
    repeat (5) begin
      if (bi0.tx_valid_o !== 1'b0) extra++;
      @(negedge clk);
    end
    bi0.tx_ready_i = 1'b0;
    tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL bp_extra: got %0d extra tx cycles want 0", extra); end
  endtask

  task automatic test_timeout;
    int errs, first, got, unst, busy_pre;
    send_range(1, 0, 4);
    errs = 0; first = -1; busy_pre = -1;
    for (int i = 1; i <= GAP + 10; i++) begin
      @(negedge clk);
      if (i == GAP - 1) busy_pre = int'(bi0.busy_o);
      if (bi0.frame_err_o === 1'b1) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    tests_run++; if (first !== GAP) begin tests_failed++; $display("FAIL timeout_when: got cycle %0d want %0d", first, GAP); end
    tests_run++; if (errs !== 1) begin tests_failed++; $display("FAIL timeout_pulses: got %0d want 1", errs); end
    tests_run++; if (busy_pre !== 1 || bi0.busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_busy: got pre=%0d post=%b want 1 0", busy_pre, bi0.busy_o);
    end
    send_range(0, 0, FB - 1);
    tests_run++; if (bi0.vec_valid_o !== 1'b1 || bi0.vec_o !== build_vec(0)) begin
      tests_failed++; $display("FAIL resync_frame: got valid=%b bad byte %0d want valid=1 bad byte -1", bi0.vec_valid_o, first_diff(bi0.vec_o, build_vec(0)));
    end
    handoff(build_vec(0));
    run_tx(FB, 100, got, unst);
    tests_run++; if (got !== FB) begin tests_failed++; $display("FAIL resync_drain: got %0d want %0d", got, FB); end
    // A byte on the very cycle the timeout would fire must be kept.
    send_range(0, 0, 2);
    errs = 0;
    repeat (GAP - 1) begin
      @(negedge clk);
      if (bi0.frame_err_o === 1'b1) errs++;
    end
    send_byte(pat(0, 3));
    repeat (3) begin
      if (bi0.frame_err_o === 1'b1) errs++;
      @(negedge clk);
    end
    tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL late_byte_err: got %0d pulses want 0", errs); end
    send_range(0, 4, FB - 1);
    tests_run++; if (bi0.vec_valid_o !== 1'b1 || bi0.vec_o !== build_vec(0)) begin
      tests_failed++; $display("FAIL late_byte_frame: got valid=%b bad byte %0d want valid=1 bad byte -1", bi0.vec_valid_o, first_diff(bi0.vec_o, build_vec(0)));
    end
    handoff(build_vec(0));
    run_tx(FB, 100, got, unst);
  endtask

  task automatic test_overrun;
    int got, unst, bad;
    send_range(1, 0, FB - 1);
    bi0.vec_ready_i = 1'b1;
    @(negedge clk);
    bi0.vec_ready_i = 1'b0;
    send_byte(8'hEE);
    tests_run++; if (bi0.overrun_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_wait: got %b want 1", bi0.overrun_o); end
    tests_run++; if (bi0.res_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_wait_state: got res_ready=%b want 1", bi0.res_ready_o); end
    @(negedge clk);
    tests_run++; if (bi0.overrun_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_pulse_width: got %b want 0", bi0.overrun_o); end
    bi0.res_i = build_vec(2);
    bi0.res_valid_i = 1'b1;
    @(negedge clk);
    bi0.res_valid_i = 1'b0;
    send_byte(8'hDD);
    tests_run++; if (bi0.overrun_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_send: got %b want 1", bi0.overrun_o); end
    tests_run++; if (bi0.tx_valid_o !== 1'b1 || bi0.tx_data_o !== pat(2, 0)) begin
      tests_failed++; $display("FAIL ovr_send_hold: got valid=%b data=%h want 1 %h", bi0.tx_valid_o, bi0.tx_data_o, pat(2, 0));
    end
    run_tx(FB, 100, got, unst);
    bad = 0;
    for (int k = 0; k < got; k++) if (txq[k] !== pat(2, k)) bad++;
    tests_run++; if (got !== FB || bad !== 0) begin tests_failed++; $display("FAIL ovr_tx_frame: got %0d bytes %0d wrong want %0d 0", got, bad, FB); end
  endtask

  task automatic test_reset_mid_send;
    int got, unst, bad;
    send_range(0, 0, FB - 1);
    handoff(build_vec(1));
    run_tx(40, 100, got, unst);
    tests_run++; if (bi0.tx_data_o !== pat(1, 40)) begin tests_failed++; $display("FAIL mid_byte40: got %h want %h", bi0.tx_data_o, pat(1, 40)); end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (bi0.tx_valid_o !== 1'b0 || bi0.tx_data_o !== 8'h00) begin
      tests_failed++; $display("FAIL mid_rst_tx: got valid=%b data=%h want 0 00", bi0.tx_valid_o, bi0.tx_data_o);
    end
    tests_run++; if (bi0.vec_o !== '0 || bi0.vec_valid_o !== 1'b0 || bi0.res_ready_o !== 1'b0 || bi0.busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL mid_rst_outs: got vec_valid=%b res_ready=%b busy=%b vec_nonzero=%b want 0 0 0 0",
        bi0.vec_valid_o, bi0.res_ready_o, bi0.busy_o, |bi0.vec_o);
    end
    rst_n = 1'b1;
    bi0.tx_ready_i = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bi0.tx_valid_o !== 1'b0) bad++;
    end
    bi0.tx_ready_i = 1'b0;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL mid_rst_trailing: got %0d tx cycles want 0", bad); end
    send_range(2, 0, FB - 1);
    tests_run++; if (bi0.vec_o !== build_vec(2)) begin tests_failed++; $display("FAIL fresh_vec: bad byte %0d want -1", first_diff(bi0.vec_o, build_vec(2))); end
    handoff(build_vec(2));
    run_tx(FB, 100, got, unst);
    bad = 0;
    for (int k = 0; k < got; k++) if (txq[k] !== pat(2, k)) bad++;
    tests_run++; if (got !== FB || bad !== 0) begin tests_failed++; $display("FAIL fresh_tx: got %0d bytes %0d wrong want %0d 0", got, bad, FB); end
  endtask

  task automatic test_small_cfg;
    int errs;
    for (int k = 0; k < 5; k++) begin
      bi1.rx_data_i = 8'(k); bi1.rx_valid_i = 1'b1; @(negedge clk); bi1.rx_valid_i = 1'b0;
    end
    errs = 0;
    repeat (10000) begin
      @(negedge clk);
      if (bi1.frame_err_o === 1'b1) errs++;
    end
    tests_run++; if (errs !== 0 || bi1.busy_o !== 1'b1) begin tests_failed++; $display("FAIL small_no_timeout: got errs=%0d busy=%b want 0 1", errs, bi1.busy_o); end
    for (int k = 5; k < 12; k++) begin
      tests_run++; if (bi1.vec_valid_o !== 1'b0) begin tests_failed++; $display("FAIL small_early_valid%0d: got 1 want 0", k); end
      bi1.rx_data_i = 8'(k); bi1.rx_valid_i = 1'b1; @(negedge clk); bi1.rx_valid_i = 1'b0;
    end
    tests_run++; if (bi1.vec_valid_o !== 1'b1) begin tests_failed++; $display("FAIL small_valid: got %b want 1", bi1.vec_valid_o); end
    tests_run++; if (bi1.vec_o[47:24] !== 24'h050403) begin tests_failed++; $display("FAIL small_word1: got %h want 050403", bi1.vec_o[47:24]); end
    tests_run++; if (bi1.vec_o[23:0] !== 24'h020100 || bi1.vec_o[95:72] !== 24'h0B0A09) begin
      tests_failed++; $display("FAIL small_word0_3: got %h %h want 020100 0b0a09", bi1.vec_o[23:0], bi1.vec_o[95:72]);
    end
  endtask

  task automatic test_single_byte;
    bi2.rx_data_i = 8'hA5; bi2.rx_valid_i = 1'b1; @(negedge clk); bi2.rx_valid_i = 1'b0;
    tests_run++; if (bi2.vec_valid_o !== 1'b1 || bi2.vec_o !== 8'hA5) begin
      tests_failed++; $display("FAIL single_vec: got valid=%b vec=%h want 1 a5", bi2.vec_valid_o, bi2.vec_o);
    end
    bi2.vec_ready_i = 1'b1; @(negedge clk); bi2.vec_ready_i = 1'b0;
    bi2.res_i = 8'h5A; bi2.res_valid_i = 1'b1; @(negedge clk); bi2.res_valid_i = 1'b0;
    tests_run++; if (bi2.tx_valid_o !== 1'b1 || bi2.tx_data_o !== 8'h5A) begin
      tests_failed++; $display("FAIL single_tx: got valid=%b data=%h want 1 5a", bi2.tx_valid_o, bi2.tx_data_o);
    end
    bi2.tx_ready_i = 1'b1; @(negedge clk); bi2.tx_ready_i = 1'b0;
    tests_run++; if (bi2.tx_valid_o !== 1'b0 || bi2.busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL single_done: got tx_valid=%b busy=%b want 0 0", bi2.tx_valid_o, bi2.busy_o);
    end
  endtask

  initial begin
    bi0.rx_data_i = '0; bi0.rx_valid_i = 1'b0; bi0.vec_ready_i = 1'b0;
    bi0.res_i = '0; bi0.res_valid_i = 1'b0; bi0.tx_ready_i = 1'b0;
    bi1.rx_data_i = '0; bi1.rx_valid_i = 1'b0; bi1.vec_ready_i = 1'b0;
    bi1.res_i = '0; bi1.res_valid_i = 1'b0; bi1.tx_ready_i = 1'b0;
    bi2.rx_data_i = '0; bi2.rx_valid_i = 1'b0; bi2.vec_ready_i = 1'b0;
    bi2.res_i = '0; bi2.res_valid_i = 1'b0; bi2.tx_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_loopback();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_reset_mid_send();
    test_small_cfg();
    test_single_byte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
